// File: rtl/c17_stimulus_gen.sv
`default_nettype none
// ============================================================================
//  Module      : c17_stimulus_gen
//  Description : Clocked pseudo-random stimulus source for the c17 NOR
//                evaluation netlists. Drives a 5-bit vector {N7,N6,N3,N2,N1}
//                from a 16-bit Galois LFSR. Each vector is held for a
//                programmable number of cycles. An optional single-bit
//                glitch pulse can be injected on each vector.
//  Options     : `C17_GLITCH_INJECT_EN enables the GLITCH state. When it is
//                not defined, glitch_sel and glitch_cycles are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module c17_stimulus_gen #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      num_vectors,
    input  logic [CNT_W-1:0] hold_cycles,
    input  logic [2:0]       glitch_sel,
    input  logic [CNT_W-1:0] glitch_cycles,
    output logic [4:0]       stim,
    output logic             vec_valid,
    output logic [15:0]      vec_idx,
    output logic             busy,
    output logic             done
);

    // An all-zero LFSR state would lock up, so a zero seed is promoted to 1.
    localparam logic [15:0] c_seed_init = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] c_lfsr_taps = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
`ifdef C17_GLITCH_INJECT_EN
        ST_GLITCH = 3'd2,
`endif
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [15:0]      r_lfsr;
    logic [15:0]      w_lfsr_next;
    logic [4:0]       r_stim;
    logic             r_vec_valid;
    logic [15:0]      r_vec_idx;
    logic [15:0]      r_last_idx;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] r_cnt;

    // Control strobes decoded by the FSM for the datapath
    logic             w_accept;
    logic             w_apply_exit;
    logic             w_cnt_dec;
    logic             w_next_vec;

`ifdef C17_GLITCH_INJECT_EN
    logic [4:0]       r_glitch_mask;
    logic [4:0]       w_glitch_mask;
    logic             w_glitch_req;
    logic             w_glitch_enter;
    logic             w_glitch_restore;
    logic             w_hold_load;

    // Glitch is only requested for a non-zero width on a valid bit position
    assign w_glitch_req  = (glitch_cycles != '0) && (glitch_sel <= 3'd4);
    assign w_glitch_mask = 5'b00001 << glitch_sel;
`else
    // Glitch ports exist for pin compatibility but carry no function here
    logic             w_unused_glitch;
    assign w_unused_glitch = ^{glitch_sel, glitch_cycles};
`endif

    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_lfsr_taps : 16'h0000);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath strobe decode
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_apply_exit = 1'b0;
        w_cnt_dec    = 1'b0;
        w_next_vec   = 1'b0;
`ifdef C17_GLITCH_INJECT_EN
        w_glitch_enter   = 1'b0;
        w_glitch_restore = 1'b0;
        w_hold_load      = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                // abort in IDLE suppresses a simultaneous start
                if (!abort && start && (num_vectors != 16'h0000)) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_apply_exit = 1'b1;
                    w_state_next = ST_HOLD;
`ifdef C17_GLITCH_INJECT_EN
                    if (w_glitch_req) begin
                        w_glitch_enter = 1'b1;
                        w_state_next   = ST_GLITCH;
                    end
`endif
                end
            end
`ifdef C17_GLITCH_INJECT_EN
            ST_GLITCH: begin
                if (abort) begin
                    // Leave the vector clean even when the run is cut short
                    w_glitch_restore = 1'b1;
                    w_state_next     = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_glitch_restore = 1'b1;
                    w_hold_load      = 1'b1;
                    w_state_next     = ST_HOLD;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
`endif
            ST_HOLD: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_dec = 1'b1;
                end else if (r_vec_idx == r_last_idx) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_next_vec   = 1'b1;
                    w_state_next = ST_APPLY;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Run configuration and vector index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_idx <= 16'h0000;
            r_hold     <= '0;
            r_vec_idx  <= 16'h0000;
        end else if (w_accept) begin
            r_last_idx <= num_vectors - 16'd1;
            r_hold     <= hold_cycles;
            r_vec_idx  <= 16'h0000;
        end else if (w_next_vec) begin
            r_vec_idx  <= r_vec_idx + 16'd1;
        end
    end

    // LFSR advances exactly once per vector, on APPLY exit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= c_seed_init;
        end else if (w_apply_exit) begin
            r_lfsr <= w_lfsr_next;
        end
    end

    // Stimulus register: new vector on APPLY exit, glitch bit flips in/out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stim <= 5'h00;
        end else if (w_apply_exit) begin
`ifdef C17_GLITCH_INJECT_EN
            r_stim <= w_glitch_enter ? (w_lfsr_next[4:0] ^ w_glitch_mask)
                                     : w_lfsr_next[4:0];
`else
            r_stim <= w_lfsr_next[4:0];
`endif
        end
`ifdef C17_GLITCH_INJECT_EN
        else if (w_glitch_restore) begin
            r_stim <= r_stim ^ r_glitch_mask;
        end
`endif
    end

`ifdef C17_GLITCH_INJECT_EN
    // Remember which bit was flipped so the restore is independent of glitch_sel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_glitch_mask <= 5'h00;
        end else if (w_glitch_enter) begin
            r_glitch_mask <= w_glitch_mask;
        end
    end
`endif

    // Shared down-counter for glitch width and hold duration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_apply_exit) begin
`ifdef C17_GLITCH_INJECT_EN
            // GLITCH spans glitch_cycles cycles including the terminal count of 0
            r_cnt <= w_glitch_enter ? (glitch_cycles - 1'b1) : r_hold;
`else
            r_cnt <= r_hold;
`endif
        end
`ifdef C17_GLITCH_INJECT_EN
        else if (w_hold_load) begin
            r_cnt <= r_hold;
        end
`endif
        else if (w_cnt_dec) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // One-cycle strobe marking the first cycle of a fresh vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_valid <= 1'b0;
        end else begin
            r_vec_valid <= w_apply_exit;
        end
    end

    assign stim      = r_stim;
    assign vec_valid = r_vec_valid;
    assign vec_idx   = r_vec_idx;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_c17_stimulus_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_c17_stimulus_gen
//  Description : Directed self-checking bench for c17_stimulus_gen. A second
//                instance with SEED=0 covers the zero-seed substitution.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_c17_stimulus_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        start_z;
    logic        abort;
    logic [15:0] num_vectors;
    logic [7:0]  hold_cycles;
    logic [2:0]  glitch_sel;
    logic [7:0]  glitch_cycles;

    logic [4:0]  stim,      z_stim;
    logic        vec_valid, z_vec_valid;
    logic [15:0] vec_idx,   z_vec_idx;
    logic        busy,      z_busy;
    logic        done,      z_done;

    int n_checks;
    int n_fail;

    c17_stimulus_gen #(.SEED(16'hACE1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_vectors(num_vectors), .hold_cycles(hold_cycles),
        .glitch_sel(glitch_sel), .glitch_cycles(glitch_cycles),
        .stim(stim), .vec_valid(vec_valid), .vec_idx(vec_idx),
        .busy(busy), .done(done)
    );

    c17_stimulus_gen #(.SEED(16'h0000), .CNT_W(8)) dut_zero (
        .clk(clk), .rst_n(rst_n), .start(start_z), .abort(abort),
        .num_vectors(num_vectors), .hold_cycles(hold_cycles),
        .glitch_sel(glitch_sel), .glitch_cycles(glitch_cycles),
        .stim(z_stim), .vec_valid(z_vec_valid), .vec_idx(z_vec_idx),
        .busy(z_busy), .done(z_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; start_z = 1'b0; abort = 1'b0;
        num_vectors = 16'd0; hold_cycles = 8'd0;
        glitch_sel = 3'd0; glitch_cycles = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pulses start for one edge (edge 0); returns at cycle 1
    task automatic begin_run(input logic [15:0] n, input logic [7:0] h);
        @(negedge clk);
        num_vectors = n; hold_cycles = h; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (stim !== 5'h00) begin n_fail++; $display("FAIL reset_stim: got %h expected 00", stim); end
        n_checks++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vec_valid: got %b expected 0", vec_valid); end
        n_checks++; if (vec_idx !== 16'd0) begin n_fail++; $display("FAIL reset_vec_idx: got %0d expected 0", vec_idx); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_zero_vectors();
        begin_run(16'd0, 8'd3);
        for (int c = 1; c <= 3; c++) begin
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_vec_busy c%0d: got %b expected 0", c, busy); end
            n_checks++; if (stim !== 5'h00) begin n_fail++; $display("FAIL zero_vec_stim c%0d: got %h expected 00", c, stim); end
            next_cycle();
        end
    endtask

    // Two vectors, hold 3; a second start (with a different count) lands mid-run
    task automatic test_basic_run();
        logic [4:0]  e_stim;
        logic        e_valid, e_busy, e_done;
        logic [15:0] e_idx;
        begin_run(16'd2, 8'd3);
        for (int c = 1; c <= 13; c++) begin
            e_stim  = (c < 2) ? 5'h00 : ((c < 7) ? 5'h10 : 5'h18);
            e_valid = (c == 2) || (c == 7);
            e_idx   = (c <= 5) ? 16'd0 : 16'd1;
            e_busy  = (c <= 11);
            e_done  = (c == 11);
            n_checks++; if (stim !== e_stim) begin n_fail++; $display("FAIL run_stim c%0d: got %h expected %h", c, stim, e_stim); end
            n_checks++; if (vec_valid !== e_valid) begin n_fail++; $display("FAIL run_vec_valid c%0d: got %b expected %b", c, vec_valid, e_valid); end
            n_checks++; if (vec_idx !== e_idx) begin n_fail++; $display("FAIL run_vec_idx c%0d: got %0d expected %0d", c, vec_idx, e_idx); end
            n_checks++; if (busy !== e_busy) begin n_fail++; $display("FAIL run_busy c%0d: got %b expected %b", c, busy, e_busy); end
            n_checks++; if (done !== e_done) begin n_fail++; $display("FAIL run_done c%0d: got %b expected %b", c, done, e_done); end
            if (c == 4) begin start = 1'b1; num_vectors = 16'd5; end
            if (c == 5) start = 1'b0;
            next_cycle();
        end
    endtask

    // Reset asserted between edges while in HOLD takes effect immediately
    task automatic test_async_reset();
        begin_run(16'd3, 8'd5);
        next_cycle();
        n_checks++; if (stim !== 5'h1C) begin n_fail++; $display("FAIL continue_stim: got %h expected 1c", stim); end
        n_checks++; if (vec_valid !== 1'b1) begin n_fail++; $display("FAIL continue_valid: got %b expected 1", vec_valid); end
        next_cycle();
        next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (stim !== 5'h00) begin n_fail++; $display("FAIL async_rst_stim: got %h expected 00", stim); end
        n_checks++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b expected 0", vec_valid); end
        n_checks++; if (vec_idx !== 16'd0) begin n_fail++; $display("FAIL async_rst_idx: got %0d expected 0", vec_idx); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL async_rst_done: got %b expected 0", done); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_abort();
        begin_run(16'd2, 8'd3);
        for (int c = 1; c <= 10; c++) begin
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done c%0d: got %b expected 0", c, done); end
            if (c >= 2) begin
                n_checks++; if (stim !== 5'h10) begin n_fail++; $display("FAIL abort_stim c%0d: got %h expected 10", c, stim); end
            end
            if (c == 5) begin
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy c5: got %b expected 0", busy); end
            end
            if (c == 4) abort = 1'b1;
            if (c == 5) abort = 1'b0;
            next_cycle();
        end
        // start and abort together in IDLE: abort wins
        @(negedge clk);
        num_vectors = 16'd1; hold_cycles = 8'd0; start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_busy: got %b expected 0", busy); end
        // Next run continues the LFSR sequence
        begin_run(16'd1, 8'd0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rerun_busy c1: got %b expected 1", busy); end
        next_cycle();
        n_checks++; if (stim !== 5'h18) begin n_fail++; $display("FAIL rerun_stim c2: got %h expected 18", stim); end
        n_checks++; if (vec_valid !== 1'b1) begin n_fail++; $display("FAIL rerun_valid c2: got %b expected 1", vec_valid); end
        next_cycle();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rerun_done c3: got %b expected 1", done); end
        next_cycle();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rerun_idle c4: got %b expected 0", busy); end
    endtask

    // glitch_sel=2, glitch_cycles=2, hold 1, one vector from a fresh seed
    task automatic test_glitch();
        logic [4:0] e_stim  [0:5];
        logic       e_valid [0:5];
        logic       e_done  [0:5];
        logic       e_busy  [0:5];
        int         n_cyc;
        do_reset();
        glitch_sel = 3'd2; glitch_cycles = 8'd2;
`ifdef C17_GLITCH_INJECT_EN
        e_stim  = '{5'h14, 5'h14, 5'h10, 5'h10, 5'h10, 5'h10};
        e_valid = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        e_done  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        e_busy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        n_cyc   = 6;
`else
        e_stim  = '{5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10};
        e_valid = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        e_done  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        e_busy  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        n_cyc   = 4;
`endif
        begin_run(16'd1, 8'd1);
        next_cycle();
        for (int i = 0; i < n_cyc; i++) begin
            n_checks++; if (stim !== e_stim[i]) begin n_fail++; $display("FAIL glitch_stim c%0d: got %h expected %h", i + 2, stim, e_stim[i]); end
            n_checks++; if (vec_valid !== e_valid[i]) begin n_fail++; $display("FAIL glitch_valid c%0d: got %b expected %b", i + 2, vec_valid, e_valid[i]); end
            n_checks++; if (done !== e_done[i]) begin n_fail++; $display("FAIL glitch_done c%0d: got %b expected %b", i + 2, done, e_done[i]); end
            n_checks++; if (busy !== e_busy[i]) begin n_fail++; $display("FAIL glitch_busy c%0d: got %b expected %b", i + 2, busy, e_busy[i]); end
            next_cycle();
        end
        glitch_sel = 3'd0; glitch_cycles = 8'd0;
    endtask

    // SEED=0 runs from state 1: B400,5A00,2D00,1680,0B40,05A0,02D0,0168,00B4
    task automatic test_zero_seed();
        logic [4:0] e_vec [0:8];
        e_vec = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h10, 5'h08, 5'h14};
        do_reset();
        @(negedge clk);
        num_vectors = 16'd9; hold_cycles = 8'd0; start_z = 1'b1;
        @(posedge clk);
        #1;
        start_z = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if ((c % 2) == 0 && c <= 18) begin
                n_checks++; if (z_stim !== e_vec[c/2 - 1]) begin n_fail++; $display("FAIL zseed_stim v%0d: got %h expected %h", c/2, z_stim, e_vec[c/2 - 1]); end
                n_checks++; if (z_vec_valid !== 1'b1) begin n_fail++; $display("FAIL zseed_valid c%0d: got %b expected 1", c, z_vec_valid); end
                n_checks++; if (z_vec_idx !== 16'(c/2 - 1)) begin n_fail++; $display("FAIL zseed_idx c%0d: got %0d expected %0d", c, z_vec_idx, c/2 - 1); end
            end else begin
                n_checks++; if (z_vec_valid !== 1'b0) begin n_fail++; $display("FAIL zseed_valid c%0d: got %b expected 0", c, z_vec_valid); end
            end
            n_checks++; if (z_done !== (c == 19)) begin n_fail++; $display("FAIL zseed_done c%0d: got %b expected %b", c, z_done, (c == 19)); end
            n_checks++; if (z_busy !== (c <= 19)) begin n_fail++; $display("FAIL zseed_busy c%0d: got %b expected %b", c, z_busy, (c <= 19)); end
            next_cycle();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_zero_vectors();
        test_basic_run();
        test_async_reset();
        test_abort();
        test_glitch();
        test_zero_seed();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/c17_stimulus_gen.md
# c17_stimulus_gen

Clocked stimulus source for the c17 NOR evaluation netlists. Produces pseudo-random 5-bit input vectors on the N1/N2/N3/N6/N7 primary-input nets that feed the pulse-shaping chains. Each vector is held for a programmable number of cycles, and the block can optionally inject a single-input glitch pulse. Sits upstream of the netlist under test and drives the `*_PWL` inputs in mixed-signal and gate-level benches.

## Interface
- `SEED`, 16'hACE1: LFSR reset value; 16'h0000 is replaced by 16'h0001.
- `CNT_W`, 8: width of hold and glitch counters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a run; sampled in IDLE only.
- `abort` in 1: synchronous stop; highest priority outside reset.
- `num_vectors` in 16: vectors per run; latched on accepted `start`.
- `hold_cycles` in CNT_W: extra HOLD cycles per vector; latched on accepted `start`.
- `glitch_sel` in 3: input bit to glitch (0..4).
- `glitch_cycles` in CNT_W: glitch width in cycles; 0 disables glitching.
- `stim` out 5: registered stimulus, bit order {N7,N6,N3,N2,N1} = [4:0].
- `vec_valid` out 1: one-cycle strobe in the first cycle a new vector is on `stim`.
- `vec_idx` out 16: index of the current vector, 0-based.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle strobe at normal run completion.

## Operation
- States: IDLE, APPLY, GLITCH, HOLD, DONE.
- IDLE:
  - `start`=1 and `num_vectors`≠0: latch `num_vectors` and `hold_cycles`, clear `vec_idx`, go to APPLY.
  - `start` with `num_vectors`=0 is ignored.
- APPLY (1 cycle): on exit, `lfsr` and `stim` both update from `lfsr_next`; `stim` takes `lfsr_next[4:0]`. Set `vec_valid`=1 for the next cycle and load `cnt`.
- LFSR step: Galois right-shift, `lfsr_next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0)`. Advances exactly once per vector.
- HOLD:
  - `cnt`≠0: decrement `cnt`.
  - `cnt`=0 and `vec_idx`=`num_vectors`−1: go to DONE.
  - `cnt`=0 otherwise: increment `vec_idx`, go to APPLY.
- DONE (1 cycle): `done`=1, then go to IDLE. `stim` keeps the last vector.
- `abort`=1 in any non-IDLE state: go to IDLE next cycle.
  - `stim` and `lfsr` keep their values.
  - `done` is not asserted.
  - A GLITCH in progress is restored first (the glitched bit is un-inverted).
- `start` while `busy` is ignored. `start` and `abort` together in IDLE: `abort` wins and the start is ignored.
- The LFSR is not reseeded between runs; a new run continues the sequence.

## Timing
- Reset values: `stim`=0, `lfsr`=SEED (0→1), `vec_valid`=0, `vec_idx`=0, `busy`=0, `done`=0, state IDLE.
- `start` accepted at edge 0: APPLY in cycle 1; first vector and `vec_valid` visible in cycle 2.
- Per-vector period with no glitch: `hold_cycles`+2 cycles (1 APPLY + `hold_cycles`+1 HOLD).
- `done` rises one cycle after the final HOLD cycle with `cnt`=0.
- `hold_cycles`=0: vectors change every 2 cycles.
- No combinational paths from inputs to outputs.

## Configuration
- `C17_GLITCH_INJECT_EN` defined:
  - GLITCH state is compiled in and entered after APPLY when `glitch_cycles`≠0 and `glitch_sel`≤4.
  - During GLITCH, `stim[glitch_sel]` is inverted for exactly `glitch_cycles` cycles, then restored, then HOLD is entered with `cnt`=`hold_cycles`.
  - Vector period grows by `glitch_cycles`.
- `C17_GLITCH_INJECT_EN` undefined:
  - GLITCH state is absent; `glitch_sel` and `glitch_cycles` remain as ports but are ignored.
  - APPLY always goes directly to HOLD.

## Test plan
- Reset: assert `rst_n`=0 mid-HOLD with no clock edge -> all outputs return immediately to reset values; `stim`=5'h00.
- SEED=16'hACE1, `num_vectors`=2, `hold_cycles`=3, `start` at edge 0 -> `stim`=5'h10 with `vec_valid` in cycle 2; `stim`=5'h18 with `vec_valid` in cycle 7; `done`=1 in cycle 11; `busy` low in cycle 12.
- `num_vectors`=0 with `start` -> state stays IDLE, `busy`=0, `stim` and `lfsr` unchanged. A second `start` pulse while `busy` -> no effect on `vec_idx` or timing.
- `abort` in cycle 4 of the run above -> IDLE in cycle 5, `stim`=5'h10 held, `done` never asserted. The next run's first vector is 5'h18.
- With `C17_GLITCH_INJECT_EN`, `glitch_sel`=2, `glitch_cycles`=2, `hold_cycles`=1, one vector -> `stim` shows 5'h14 for 2 cycles, then 5'h10 for 2 cycles, then `done`.
- SEED=16'h0000 -> first vector equals the LFSR step of 16'h0001 (`lfsr`=16'hB400), giving `stim`=5'h00; the second vector is 5'h00 from 16'h5A00. Check the LFSR never reaches 0 over 65535 vectors.
